// File: rtl/clause_table_mp.sv
// Multi-port clause table: per-variable clause lists in RAM, written from the AXI config path
// during LOAD, read by NUM_RD_PORTS independent channels, zeroed by a hardware clear sequencer.
module clause_table_mp #(
    parameter int CLAUSE_COUNT           = 20,
    parameter int NSAT                   = 3,
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int DEPTH                  = 2048,
    parameter int NUM_RD_PORTS           = 4,
    parameter int OUT_REG                = 1,
    parameter int CT_WIDTH               = (VARIABLE_ADDRESS_WIDTH + 1) * (NSAT - 1) * CLAUSE_COUNT
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clear_i,
    input  logic                                     run_i,
    input  logic                                     axi_wr_en_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]        axi_wr_addr_i,
    input  logic [CT_WIDTH-1:0]                      axi_wr_clauses_i,
    output logic                                     wr_ack_o,
    output logic                                     wr_err_o,
    input  logic [NUM_RD_PORTS-1:0]                  rd_req_i,
    input  logic [NUM_RD_PORTS*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic                                     rd_ready_o,
    output logic [NUM_RD_PORTS-1:0]                  rd_valid_o,
    output logic [NUM_RD_PORTS*CT_WIDTH-1:0]         clauses_o,
    output logic                                     busy_o,
    output logic [1:0]                               state_o
);
    localparam int VAW = VARIABLE_ADDRESS_WIDTH;
    localparam int NRP = NUM_RD_PORTS;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [VAW:0]   DEPTH_L  = (VAW + 1)'(DEPTH);
    localparam logic [VAW-1:0] LAST_PTR = VAW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [VAW-1:0] ptr_q, ptr_d;
    logic           wr_ack_q, wr_ack_d;
    logic           wr_err_q, wr_err_d;
    logic [NRP-1:0] rd_v1_q;
    logic [NRP-1:0] rd_acc_s;
    logic [NRP-1:0] rd_oor_s;
    logic           wr_ok_s;
    logic           mem_we_s;
    logic [AW-1:0]  mem_waddr_s;
    logic [CT_WIDTH-1:0] mem_wdata_s;

    // Mode sequencing and write acceptance; clear_i overrides everything
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_ok_s  = axi_wr_en_i && !clear_i && (state_q == ST_LOAD) &&
                   ({1'b0, axi_wr_addr_i} < DEPTH_L);
        wr_ack_d = wr_ok_s;
        wr_err_d = axi_wr_en_i && !wr_ok_s;
        if (clear_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_LOAD;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + VAW'(1);
                    end
                end
                ST_LOAD: begin
                    if (run_i) state_d = ST_RUN;
                    else       state_d = ST_LOAD;
                end
                ST_RUN: begin
                    if (!run_i) state_d = ST_LOAD;
                    else        state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // The clear sequencer owns the shared write port while clearing
    always_comb begin
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_q[AW-1:0];
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = wr_ok_s;
            mem_waddr_s = axi_wr_addr_i[AW-1:0];
            mem_wdata_s = axi_wr_clauses_i;
        end
    end

    // Per-channel read acceptance and out-of-range detection
    always_comb begin
        rd_acc_s = '0;
        rd_oor_s = '0;
        for (int p = 0; p < NRP; p++) begin
            rd_acc_s[p] = rd_req_i[p] && (state_q != ST_CLEAR) && !clear_i;
            rd_oor_s[p] = !({1'b0, rd_addr_i[p*VAW +: VAW]} < DEPTH_L);
        end
    end

    // Control registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_v1_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_v1_q  <= rd_acc_s;
        end
    end

    assign wr_ack_o   = wr_ack_q;
    assign wr_err_o   = wr_err_q;
    assign busy_o     = (state_q == ST_CLEAR);
    assign rd_ready_o = (state_q != ST_CLEAR);
    assign state_o    = state_q;

    for (genvar p = 0; p < NRP; p++) begin : g_port
        logic [CT_WIDTH-1:0] mem [DEPTH];
        logic [CT_WIDTH-1:0] rd1_q;
        logic [VAW-1:0]      raddr_s;

        assign raddr_s = rd_addr_i[p*VAW +: VAW];

        // Each replica sees every write so all channels read the same contents
        always_ff @(posedge clk_i) begin
            if (mem_we_s) mem[mem_waddr_s] <= mem_wdata_s;
        end

        // Synchronous read returns pre-write contents on a same-edge collision
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd1_q <= '0;
            end else if (rd_acc_s[p]) begin
                rd1_q <= rd_oor_s[p] ? '0 : mem[raddr_s[AW-1:0]];
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic                v2_q, v2_d;
            logic [CT_WIDTH-1:0] out_q, out_d;

            // Output stage captures only delivered data so the bus holds between beats
            always_comb begin
                v2_d = rd_v1_q[p] && !clear_i;
                if (v2_d) out_d = rd1_q;
                else      out_d = out_q;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    v2_q  <= 1'b0;
                    out_q <= '0;
                end else begin
                    v2_q  <= v2_d;
                    out_q <= out_d;
                end
            end

            assign rd_valid_o[p]                  = v2_q;
            assign clauses_o[p*CT_WIDTH +: CT_WIDTH] = out_q;
        end else begin : g_noreg
            assign rd_valid_o[p]                  = rd_v1_q[p];
            assign clauses_o[p*CT_WIDTH +: CT_WIDTH] = rd1_q;
        end
    end
endmodule

// File: tb/tb_clause_table_mp.sv
// Self-checking bench for clause_table_mp: a mode/memory reference model checks every cycle,
// plus directed tables and sequences for clear timing, collisions, write rejection and range limits.
module tb_clause_table_mp;
    localparam int VAW = 11, DEPTH = 2048, NRP = 4, CT = 480;
    localparam int BVAW = 12, BCT = 26;

    localparam logic [CT-1:0] PAT_A = {6{80'hAABBCCDDEEFF00118899}};
    localparam logic [CT-1:0] PAT_F = {480{1'b1}};
    localparam logic [CT-1:0] PAT_B = {15{32'h0BADF00D}};
    localparam logic [CT-1:0] PAT_C = {15{32'h12345678}};
    localparam logic [CT-1:0] PAT_D = {15{32'hDEADBEEF}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                clear, run, wr_en;
    logic [VAW-1:0]      wr_addr;
    logic [CT-1:0]       wr_data;
    logic                wr_ack, wr_err;
    logic [NRP-1:0]      rd_req;
    logic [NRP*VAW-1:0]  rd_addr;
    logic                rd_ready;
    logic [NRP-1:0]      rd_valid;
    logic [NRP*CT-1:0]   clauses;
    logic                busy;
    logic [1:0]          state;

    logic                b_wr_en;
    logic [BVAW-1:0]     b_wr_addr;
    logic [BCT-1:0]      b_wr_data;
    logic                b_wr_ack, b_wr_err;
    logic [0:0]          b_rd_req;
    logic [BVAW-1:0]     b_rd_addr;
    logic                b_rd_ready;
    logic [0:0]          b_rd_valid;
    logic [BCT-1:0]      b_clauses;
    logic                b_busy;
    logic [1:0]          b_state;

    clause_table_mp dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .run_i(run),
        .axi_wr_en_i(wr_en), .axi_wr_addr_i(wr_addr), .axi_wr_clauses_i(wr_data),
        .wr_ack_o(wr_ack), .wr_err_o(wr_err),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rd_valid_o(rd_valid), .clauses_o(clauses), .busy_o(busy), .state_o(state)
    );

    clause_table_mp #(
        .CLAUSE_COUNT(1), .NSAT(3), .VARIABLE_ADDRESS_WIDTH(BVAW), .DEPTH(2048),
        .NUM_RD_PORTS(1), .OUT_REG(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .run_i(1'b0),
        .axi_wr_en_i(b_wr_en), .axi_wr_addr_i(b_wr_addr), .axi_wr_clauses_i(b_wr_data),
        .wr_ack_o(b_wr_ack), .wr_err_o(b_wr_err),
        .rd_req_i(b_rd_req), .rd_addr_i(b_rd_addr), .rd_ready_o(b_rd_ready),
        .rd_valid_o(b_rd_valid), .clauses_o(b_clauses), .busy_o(b_busy), .state_o(b_state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 clear / 1 load / 2 run, memory array, expected read beats by edge
    logic [CT-1:0]  ref_mem [DEPTH];
    int             mode, clr_left, edge_n;
    logic [NRP-1:0] slot_v [4];
    logic [CT-1:0]  slot_d [4][NRP];
    logic [CT-1:0]  last_d [NRP];
    logic           exp_ack, exp_err;

    typedef struct {
        logic          run;
        logic          wr_en;
        int            addr;
        logic [CT-1:0] data;
        logic          ack;
        logic          err;
        int            st;
    } wvec_t;
    wvec_t tbl [6];

    task automatic chk_d(input string name, input logic [CT-1:0] act, input logic [CT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        mode = 0;
        clr_left = DEPTH;
        for (int s = 0; s < 4; s++) slot_v[s] = '0;
        for (int p = 0; p < NRP; p++) last_d[p] = '0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*VAW +: VAW] = VAW'(a);
    endtask

    task automatic reset_checks();
        chk_i("rst_state", int'(state), 0);
        chk_i("rst_busy", int'(busy), 1);
        chk_i("rst_ready", int'(rd_ready), 0);
        chk_i("rst_valid", int'(rd_valid), 0);
        chk_i("rst_ack_err", int'({wr_ack, wr_err}), 0);
        for (int p = 0; p < NRP; p++) chk_d("rst_clauses", clauses[p*CT +: CT], '0);
    endtask

    // One clock: predict from current inputs, advance the edge, compare all outputs
    task automatic step();
        int e;
        int a;
        logic ok;
        e = edge_n + 1;
        slot_v[(e + 1) % 4] = '0;
        if (mode != 0 && !clear) begin
            for (int p = 0; p < NRP; p++) begin
                if (rd_req[p]) begin
                    a = int'(rd_addr[p*VAW +: VAW]);
                    slot_v[(e + 1) % 4][p] = 1'b1;
                    slot_d[(e + 1) % 4][p] = (a < DEPTH) ? ref_mem[a] : '0;
                end
            end
        end
        if (clear) slot_v[e % 4] = '0;
        ok = wr_en && !clear && mode == 1 && int'(wr_addr) < DEPTH;
        exp_ack = ok;
        exp_err = wr_en && !ok;
        if (ok) ref_mem[wr_addr] = wr_data;
        if (clear) begin
            mode = 0;
            clr_left = DEPTH;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else if (mode == 0) begin
            clr_left--;
            if (clr_left == 0) mode = 1;
        end else if (mode == 1) begin
            if (run) mode = 2;
        end else begin
            if (!run) mode = 1;
        end
        @(posedge clk);
        edge_n = e;
        #1;
        chk_i("wr_ack", int'(wr_ack), int'(exp_ack));
        chk_i("wr_err", int'(wr_err), int'(exp_err));
        chk_i("state", int'(state), mode);
        chk_i("busy", int'(busy), int'(mode == 0));
        chk_i("rd_ready", int'(rd_ready), int'(mode != 0));
        for (int p = 0; p < NRP; p++) begin
            chk_i("rd_valid", int'(rd_valid[p]), int'(slot_v[e % 4][p]));
            if (slot_v[e % 4][p]) last_d[p] = slot_d[e % 4][p];
            chk_d("clauses", clauses[p*CT +: CT], last_d[p]);
        end
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        chk_i(name, n, 2048);
    endtask

    task automatic rd_one(input int p, input int a, input logic [CT-1:0] exp, input string name);
        rd_req = '0;
        rd_req[p] = 1'b1;
        set_rd(p, a);
        step();
        rd_req = '0;
        step();
        chk_i({name, "_valid"}, int'(rd_valid[p]), 1);
        chk_d(name, clauses[p*CT +: CT], exp);
    endtask

    initial begin
        int cnt;
        tbl[0] = '{run: 1'b0, wr_en: 1'b1, addr: 2047, data: PAT_B, ack: 1'b1, err: 1'b0, st: 1};
        tbl[1] = '{run: 1'b1, wr_en: 1'b1, addr: 7,    data: PAT_C, ack: 1'b1, err: 1'b0, st: 2};
        tbl[2] = '{run: 1'b1, wr_en: 1'b1, addr: 5,    data: PAT_D, ack: 1'b0, err: 1'b1, st: 2};
        tbl[3] = '{run: 1'b0, wr_en: 1'b1, addr: 6,    data: PAT_D, ack: 1'b0, err: 1'b1, st: 1};
        tbl[4] = '{run: 1'b0, wr_en: 1'b0, addr: 0,    data: PAT_D, ack: 1'b0, err: 1'b0, st: 1};
        tbl[5] = '{run: 1'b0, wr_en: 1'b1, addr: 3,    data: PAT_D, ack: 1'b1, err: 1'b0, st: 1};

        rst = 1'b1; clear = 1'b0; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_req = '0; b_rd_addr = '0;
        edge_n = 0;
        model_reset();
        #12;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;

        // 1: clear length, then a read of a cleared entry with two-edge latency
        wait_clear_done("clear_len");
        chk_i("load_state", int'(state), 1);
        rd_req = 4'b0001; set_rd(0, 500);
        step();
        rd_req = '0;
        chk_i("lat1_valid", int'(rd_valid[0]), 0);
        step();
        chk_i("lat2_valid", int'(rd_valid[0]), 1);
        chk_d("rd500", clauses[0 +: CT], '0);

        // 2: write then broadcast read on all ports
        wr_en = 1'b1; wr_addr = VAW'(1); wr_data = PAT_A;
        step();
        wr_en = 1'b0;
        chk_i("ack_a", int'(wr_ack), 1);
        rd_req = 4'b1111;
        for (int p = 0; p < NRP; p++) set_rd(p, 1);
        step();
        rd_req = '0;
        step();
        for (int p = 0; p < NRP; p++) chk_d("bcast_a", clauses[p*CT +: CT], PAT_A);

        // 3: same-edge write/read collision is read-first
        wr_en = 1'b1; wr_addr = VAW'(100); wr_data = PAT_F;
        rd_req = 4'b0100; set_rd(2, 100);
        step();
        wr_en = 1'b0;
        step();
        rd_req = '0;
        chk_d("collide_old", clauses[2*CT +: CT], '0);
        step();
        chk_d("collide_new", clauses[2*CT +: CT], PAT_F);

        // 4: write acceptance table across LOAD/RUN
        foreach (tbl[i]) begin
            run = tbl[i].run; wr_en = tbl[i].wr_en;
            wr_addr = VAW'(tbl[i].addr); wr_data = tbl[i].data;
            step();
            chk_i("tbl_ack", int'(wr_ack), int'(tbl[i].ack));
            chk_i("tbl_err", int'(wr_err), int'(tbl[i].err));
            chk_i("tbl_state", int'(state), tbl[i].st);
        end
        wr_en = 1'b0;
        rd_one(3, 5, '0, "rd5_rejected");
        rd_one(0, 6, '0, "rd6_rejected");
        rd_one(1, 7, PAT_C, "rd7_run_edge");
        rd_one(2, 2047, PAT_B, "rd2047");

        // 5: streaming port 1 over addresses 0..9
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            rd_req = (i < 10) ? 4'b0010 : 4'b0000;
            set_rd(1, i);
            step();
            if (rd_valid[1]) cnt++;
        end
        chk_i("stream_len", cnt, 10);

        // Wide-address instance: range limit and unregistered output
        chk_i("b_state", int'(b_state), 1);
        b_wr_en = 1'b1; b_wr_addr = 12'd2048; b_wr_data = 26'h2ABCDEF;
        step();
        chk_i("b_err2048", int'({b_wr_ack, b_wr_err}), 1);
        b_wr_addr = 12'd2047;
        step();
        b_wr_en = 1'b0;
        chk_i("b_ack2047", int'({b_wr_ack, b_wr_err}), 2);
        b_rd_req = 1'b1; b_rd_addr = 12'd2047;
        step();
        chk_i("b_rd2047_v", int'(b_rd_valid), 1);
        chk_i("b_rd2047", int'(b_clauses), 32'h2ABCDEF);
        b_rd_addr = 12'd2048;
        step();
        b_rd_req = 1'b0;
        chk_i("b_oor_v", int'(b_rd_valid), 1);
        chk_i("b_oor", int'(b_clauses), 0);
        step();
        chk_i("b_idle_v", int'(b_rd_valid), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            wr_en = ($urandom_range(0, 2) == 0);
            wr_addr = VAW'($urandom_range(0, 15));
            wr_data = {15{$urandom()}};
            rd_req = NRP'($urandom());
            for (int p = 0; p < NRP; p++) set_rd(p, $urandom_range(0, 15));
            step();
        end
        run = 1'b0; wr_en = 1'b0; rd_req = '0;
        step();
        step();

        // 6: clear with reads in flight, then reset in the middle of a clear
        wr_en = 1'b1; wr_addr = VAW'(1); wr_data = PAT_A;
        step();
        wr_en = 1'b0;
        rd_req = 4'b1111;
        for (int p = 0; p < NRP; p++) set_rd(p, 1);
        step();
        step();
        chk_i("inflight_valid", int'(rd_valid), 15);
        clear = 1'b1;
        step();
        clear = 1'b0; rd_req = '0;
        chk_i("flush_valid", int'(rd_valid), 0);
        chk_i("flush_busy", int'(busy), 1);
        wait_clear_done("clear2_len");
        rd_one(0, 1, '0, "rd1_cleared");
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        #2;
        model_reset();
        reset_checks();
        @(negedge clk);
        rst = 1'b0;
        wait_clear_done("clear_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clause_table_mp.md
Name: clause_table_mp

Overview:
- Multi-port successor to the single-port clause table: per-variable clause lists stored in on-chip RAM, indexed by variable address.
- Adds N independent read channels with request/valid handshake, optional output register and a hardware zero-clear sequencer.
- Adds a load/run mode: the table is writable only while loading and is read-only while the WalkSAT engine runs.
- Sits between the AXI configuration path (writes) and the parallel clause-evaluation lanes (reads).

Parameters:
- CLAUSE_COUNT, 20, clause slots stored per variable entry.
- NSAT, 3, literals per clause (the entry holds the NSAT-1 other literals).
- VARIABLE_ADDRESS_WIDTH, 11, variable address width; each literal is address plus 1 negation bit.
- DEPTH, 2048, number of entries; must satisfy DEPTH <= 2**VARIABLE_ADDRESS_WIDTH.
- NUM_RD_PORTS, 4, independent read channels.
- OUT_REG, 1, 0 or 1; adds one output pipeline stage to read data.
- CT_WIDTH, (VARIABLE_ADDRESS_WIDTH+1)*(NSAT-1)*CLAUSE_COUNT, entry width (derived, 480 with defaults).

Ports:
- clk_i  in  1  single clock; all logic is on its rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- clear_i  in  1  one-cycle pulse; restarts the zero-clear sequence from any state.
- run_i  in  1  level; 1 = run (read-only) mode, 0 = load mode.
- axi_wr_en_i  in  1  write request.
- axi_wr_addr_i  in  VARIABLE_ADDRESS_WIDTH  write address.
- axi_wr_clauses_i  in  CT_WIDTH  write data.
- wr_ack_o  out  1  one-cycle pulse: write committed.
- wr_err_o  out  1  one-cycle pulse: write rejected.
- rd_req_i  in  NUM_RD_PORTS  per-channel read request.
- rd_addr_i  in  NUM_RD_PORTS*VARIABLE_ADDRESS_WIDTH  packed read addresses; channel p uses bits [p*VAW +: VAW].
- rd_ready_o  out  1  high when read requests are accepted.
- rd_valid_o  out  NUM_RD_PORTS  per-channel data valid.
- clauses_o  out  NUM_RD_PORTS*CT_WIDTH  packed read data.
- busy_o  out  1  high while clearing.
- state_o  out  2  current state: 0 CLEAR, 1 LOAD, 2 RUN.

Behaviour:
- Reset values: state CLEAR, clear pointer 0, all rd_valid_o/wr_ack_o/wr_err_o 0, clauses_o 0, busy_o 1, rd_ready_o 0. RAM contents are not reset; the sequencer clears them.
- CLEAR:
  - Writes zero to entry ptr each cycle, ptr = 0..DEPTH-1, so the sequence takes exactly DEPTH cycles.
  - After ptr = DEPTH-1 is written, moves to LOAD the next cycle.
  - Any AXI write in this state is rejected (wr_err_o).
  - Read requests are ignored; rd_ready_o = 0.
- LOAD:
  - A write with axi_wr_addr_i < DEPTH commits at the clock edge, and wr_ack_o is high in the following cycle.
  - A write with axi_wr_addr_i >= DEPTH is dropped and wr_err_o pulses.
  - Reads are allowed.
  - run_i = 1 moves the state to RUN the next cycle; a write in that same cycle still commits.
- RUN:
  - Every write is rejected with wr_err_o; memory is unchanged.
  - run_i = 0 returns to LOAD.
- clear_i has priority over run_i and writes in every state:
  - moves to CLEAR with ptr = 0;
  - flushes all in-flight read valids;
  - a write in the same cycle is rejected.
- Reads (LOAD/RUN, rd_ready_o = 1):
  - rd_req_i[p] sampled at edge N; rd_valid_o[p] and data are high/valid at edge N+1+OUT_REG.
  - Valid lasts one cycle per request; back-to-back requests give back-to-back data (full throughput on every port).
  - Out-of-range read address (>= DEPTH) returns all zeros with valid asserted.
  - Channels are fully independent; identical addresses on several ports are legal.
- Read/write collision (same address, same edge): read returns old data (read-first).
  - Implementation: replicate the RAM per read port; every replica receives every write.
- clauses_o[p] holds its last value when rd_valid_o[p] = 0.
- Reset mid-operation:
  - Asynchronous return to reset values.
  - Pipelines are flushed.
  - Clear restarts from 0 after rst_i deasserts.

Test Plan:
1. Reset, then wait: busy_o high for exactly 2048 cycles, then state_o = 1. A read of address 500 on port 0 returns 480'h0 with rd_valid_o[0] at latency 2 (OUT_REG = 1).
2. LOAD: write 480'hAABB…8899 to address 1. wr_ack_o pulses. Requesting address 1 on all 4 ports in the same cycle returns that value on every port two edges later.
3. Same-edge write of 480'hFFFF…FF to address 100 and port-2 read of address 100: the read returns 0. A repeat read one cycle later returns 480'hFFFF…FF.
4. Set run_i = 1, write address 5: wr_err_o pulses. A subsequent read of address 5 returns 0. Write address 2047 in LOAD: acked. Write address 2048 with VAW = 12: wr_err_o.
5. Port 1 streams addresses 0..9 on consecutive cycles: rd_valid_o[1] high for 10 consecutive cycles with data in order.
6. Assert clear_i after data is loaded and while reads are in flight: pending valids drop, busy_o rises, and after 2048 cycles address 1 reads 0. Asserting rst_i mid-clear restarts the count at 0.
